// File: rtl/speckle_emu_pkg.sv
// Shared definitions for the speckle chip emulator: converter states,
// XADC word width and one-hot helpers used by the selection logic.
package speckle_emu_pkg;

  localparam int XADC_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CONV = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Callers zero-extend narrower registers to 64 bits.
  function automatic logic isOneHot(input logic [63:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
    return seen & ~multi;
  endfunction

  function automatic int oneHotIndex(input logic [63:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/emu_shift_reg.sv
// Serial-in shift register driven by a synchronized clock edge; the level
// clear wins over a simultaneous edge.
module emu_shift_reg #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_edge,
  input  logic             i_clr,
  input  logic             i_data,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_edge) begin
      r_q <= {r_q[WIDTH-2:0], i_data};
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/speckle_chip_emulator.sv
// Stand-in for the speckle sensor chip plus XADC: pixel selection by
// shift registers, a key array and a busy/eoc conversion response.
module speckle_chip_emulator
  import speckle_emu_pkg::*;
#(
  parameter int COLS        = 24,
  parameter int ROWS        = 24,
  parameter int NB_DATA     = 12,
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CYCLES = 26,
  parameter int PIX_BASE    = 'h100
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_chip_col_clk,
  input  logic                    i_chip_col_rst,
  input  logic                    i_chip_col_data,
  input  logic                    i_chip_row_clk,
  input  logic                    i_chip_row_rst,
  input  logic                    i_chip_row_ena,
  input  logic                    i_chip_row_data,
  input  logic                    i_chip_key_wren,
  input  logic                    i_adc_trigger,
  output logic                    o_adc_busy,
  output logic                    o_adc_done,
  output logic [XADC_W-1:0]       o_adc_do,
  output logic                    o_sel_valid,
  output logic                    o_sel_err,
  output logic [$clog2(ROWS)-1:0] o_sel_row,
  output logic [$clog2(COLS)-1:0] o_sel_col
);

  localparam int ROW_W    = $clog2(ROWS);
  localparam int COL_W    = $clog2(COLS);
  localparam int CNT_W    = $clog2(CONV_CYCLES + 1);
  localparam int NUM_EDGE = 4;
  localparam int NUM_IN   = 9;

  // Pins [3:0] need rising-edge detection, the rest are used as levels.
  logic [NUM_IN-1:0]          w_pins;
  logic [NUM_EDGE-1:0]        w_rise;
  logic [NUM_IN-NUM_EDGE-1:0] w_level;

  assign w_pins = {i_chip_row_data, i_chip_row_ena, i_chip_row_rst,
                   i_chip_col_data, i_chip_col_rst,
                   i_adc_trigger, i_chip_key_wren, i_chip_row_clk, i_chip_col_clk};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_sync
    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_chain <= '0;
      else        r_chain <= {r_chain[SYNC_STAGES-2:0], w_pins[g]};
    end

    if (g < NUM_EDGE) begin : g_edge
      logic r_prev;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_prev <= 1'b0;
        else        r_prev <= r_chain[SYNC_STAGES-1];
      end
      assign w_rise[g] = r_chain[SYNC_STAGES-1] & ~r_prev;
    end else begin : g_level
      assign w_level[g-NUM_EDGE] = r_chain[SYNC_STAGES-1];
    end
  end

  logic w_col_edge, w_row_edge, w_key_edge, w_trig_edge;
  logic w_col_rst, w_col_data, w_row_rst, w_row_ena, w_row_data;

  assign {w_trig_edge, w_key_edge, w_row_edge, w_col_edge} = w_rise;
  assign {w_row_data, w_row_ena, w_row_rst, w_col_data, w_col_rst} = w_level;

  logic [COLS-1:0] w_col_sr;
  logic [ROWS-1:0] w_row_sr;

  emu_shift_reg #(.WIDTH(COLS)) u_col_sr (
    .clk(clk), .rst_n(rst_n), .i_edge(w_col_edge), .i_clr(w_col_rst),
    .i_data(w_col_data), .o_q(w_col_sr)
  );

  emu_shift_reg #(.WIDTH(ROWS)) u_row_sr (
    .clk(clk), .rst_n(rst_n), .i_edge(w_row_edge), .i_clr(w_row_rst),
    .i_data(w_row_data), .o_q(w_row_sr)
  );

  logic w_col_hot, w_row_hot, w_sel_ok;

  assign w_col_hot = isOneHot(64'(w_col_sr));
  assign w_row_hot = isOneHot(64'(w_row_sr));
  assign w_sel_ok  = w_row_ena & w_row_hot & w_col_hot;

  logic             r_sel_valid, r_sel_err;
  logic [ROW_W-1:0] r_sel_row;
  logic [COL_W-1:0] r_sel_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_valid <= 1'b0;
      r_sel_err   <= 1'b0;
      r_sel_row   <= '0;
      r_sel_col   <= '0;
    end else begin
      r_sel_valid <= w_sel_ok;
      r_sel_err   <= w_row_ena & ~(w_row_hot & w_col_hot);
      r_sel_row   <= w_sel_ok ? ROW_W'(oneHotIndex(64'(w_row_sr))) : '0;
      r_sel_col   <= w_sel_ok ? COL_W'(oneHotIndex(64'(w_col_sr))) : '0;
    end
  end

  // Writes see the pre-shift register contents when a shift lands in the same cycle.
  logic [COLS-1:0] r_key [ROWS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < ROWS; r++) r_key[r] <= '0;
    end else if (w_key_edge && w_row_ena) begin
      for (int r = 0; r < ROWS; r++) begin
        if (w_row_sr[r]) r_key[r] <= w_col_sr;
      end
    end
  end

  logic               w_key_bit;
  logic [NB_DATA-1:0] w_pix;

  assign w_key_bit = r_key[r_sel_row][r_sel_col];
  assign w_pix     = (r_sel_valid && w_key_bit)
                   ? NB_DATA'(PIX_BASE + int'(r_sel_row) * COLS + int'(r_sel_col))
                   : '0;

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [NB_DATA-1:0] r_cap;
  logic               r_busy, r_done;
  logic [XADC_W-1:0]  r_do;

  // Triggers arriving outside IDLE are dropped rather than queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cap   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_do    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trig_edge) begin
            r_cap   <= w_pix;
            r_busy  <= 1'b1;
            r_cnt   <= CNT_W'(CONV_CYCLES - 1);
            r_state <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (r_cnt == '0) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_do    <= XADC_W'(r_cap) << (XADC_W - NB_DATA);
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_adc_busy  = r_busy;
  assign o_adc_done  = r_done;
  assign o_adc_do    = r_do;
  assign o_sel_valid = r_sel_valid;
  assign o_sel_err   = r_sel_err;
  assign o_sel_row   = r_sel_row;
  assign o_sel_col   = r_sel_col;

endmodule

// File: tb/tb_speckle_chip_emulator.sv
// Directed plus randomized bench for speckle_chip_emulator, checked against
// a bit-array model of the chip registers, key array and pixel formula.
module tb_speckle_chip_emulator;

  localparam int COLS        = 24;
  localparam int ROWS        = 24;
  localparam int NB_DATA     = 12;
  localparam int SYNC_STAGES = 2;
  localparam int CONV_CYCLES = 26;
  localparam int PIX_BASE    = 'h100;
  localparam int HOLD        = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        colClk = 1'b0, colRst = 1'b0, colData = 1'b0;
  logic        rowClk = 1'b0, rowRst = 1'b0, rowEna = 1'b0, rowData = 1'b0;
  logic        keyWren = 1'b0, adcTrigger = 1'b0;
  logic        adcBusy, adcDone, selValid, selErr;
  logic [15:0] adcDo;
  logic [4:0]  selRow, selCol;

  int checks = 0;
  int errors = 0;

  bit mCol [COLS];
  bit mRow [ROWS];
  bit mKey [ROWS][COLS];
  bit mEna;

  speckle_chip_emulator #(
    .COLS(COLS), .ROWS(ROWS), .NB_DATA(NB_DATA), .SYNC_STAGES(SYNC_STAGES),
    .CONV_CYCLES(CONV_CYCLES), .PIX_BASE(PIX_BASE)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_chip_col_clk(colClk), .i_chip_col_rst(colRst), .i_chip_col_data(colData),
    .i_chip_row_clk(rowClk), .i_chip_row_rst(rowRst), .i_chip_row_ena(rowEna),
    .i_chip_row_data(rowData), .i_chip_key_wren(keyWren), .i_adc_trigger(adcTrigger),
    .o_adc_busy(adcBusy), .o_adc_done(adcDone), .o_adc_do(adcDo),
    .o_sel_valid(selValid), .o_sel_err(selErr), .o_sel_row(selRow), .o_sel_col(selCol)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int c = 0; c < COLS; c++) mCol[c] = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      mRow[r] = 1'b0;
      for (int c = 0; c < COLS; c++) mKey[r][c] = 1'b0;
    end
    mEna = 1'b0;
  endtask

  function automatic int colIndex();
    int n = 0;
    int idx = -1;
    for (int c = 0; c < COLS; c++) if (mCol[c]) begin n++; idx = c; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic int rowIndex();
    int n = 0;
    int idx = -1;
    for (int r = 0; r < ROWS; r++) if (mRow[r]) begin n++; idx = r; end
    return (n == 1) ? idx : -1;
  endfunction

  function automatic logic [15:0] expectedWord();
    int ci = colIndex();
    int ri = rowIndex();
    int v;
    if (!(mEna && ci >= 0 && ri >= 0)) return 16'h0;
    if (!mKey[ri][ci]) return 16'h0;
    v = (PIX_BASE + ri * COLS + ci) % (1 << NB_DATA);
    return 16'(v << (16 - NB_DATA));
  endfunction

  task automatic shiftPair(input bit colOn, input bit colBit, input bit rowOn, input bit rowBit);
    if (colOn) colData = colBit;
    if (rowOn) rowData = rowBit;
    waitCycles(HOLD);
    if (colOn) colClk = 1'b1;
    if (rowOn) rowClk = 1'b1;
    waitCycles(HOLD);
    colClk = 1'b0;
    rowClk = 1'b0;
    waitCycles(HOLD);
    if (colOn) begin
      for (int i = COLS - 1; i > 0; i--) mCol[i] = mCol[i-1];
      mCol[0] = colBit;
    end
    if (rowOn) begin
      for (int i = ROWS - 1; i > 0; i--) mRow[i] = mRow[i-1];
      mRow[0] = rowBit;
    end
  endtask

  task automatic clearRegs();
    colRst = 1'b1;
    rowRst = 1'b1;
    waitCycles(HOLD);
    colRst = 1'b0;
    rowRst = 1'b0;
    waitCycles(HOLD);
    for (int c = 0; c < COLS; c++) mCol[c] = 1'b0;
    for (int r = 0; r < ROWS; r++) mRow[r] = 1'b0;
  endtask

  task automatic setEna(input bit b);
    rowEna = b;
    mEna = b;
    waitCycles(HOLD + 2);
  endtask

  task automatic writeKey();
    keyWren = 1'b1;
    waitCycles(HOLD);
    keyWren = 1'b0;
    waitCycles(HOLD);
    if (mEna) begin
      for (int r = 0; r < ROWS; r++)
        if (mRow[r]) for (int c = 0; c < COLS; c++) mKey[r][c] = mCol[c];
    end
  endtask

  task automatic checkSelection(input string tag);
    int ci = colIndex();
    int ri = rowIndex();
    bit good = mEna && ci >= 0 && ri >= 0;
    checkOutput({tag, ".valid"}, 32'(selValid), 32'(good));
    checkOutput({tag, ".err"},   32'(selErr),   32'(mEna && !good));
    checkOutput({tag, ".row"},   32'(selRow),   good ? 32'(ri) : 32'd0);
    checkOutput({tag, ".col"},   32'(selCol),   good ? 32'(ci) : 32'd0);
  endtask

  // Select pixel (rowIdx, colIdx) from cleared registers, optionally writing the key.
  task automatic applyStimulus(input int rowIdx, input int colIdx, input bit doKey);
    int last = (rowIdx > colIdx) ? rowIdx : colIdx;
    clearRegs();
    for (int i = 0; i <= last; i++) shiftPair(i <= colIdx, i == 0, i <= rowIdx, i == 0);
    setEna(1'b1);
    if (doKey) writeKey();
  endtask

  task automatic doConvert(input string tag, input bit retrigger);
    int busyCnt = 0;
    int doneCnt = 0;
    int doneAt = -1;
    logic [15:0] expWord = expectedWord();
    adcTrigger = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      @(negedge clk);
      if (adcBusy) busyCnt++;
      if (adcDone) begin
        doneCnt++;
        if (doneAt < 0) doneAt = n;
      end
      if (n == 4) adcTrigger = 1'b0;
      if (retrigger && n == 6) adcTrigger = 1'b1;
      if (n == 12) adcTrigger = 1'b0;
    end
    checkOutput({tag, ".busyCycles"}, 32'(busyCnt), 32'(CONV_CYCLES));
    checkOutput({tag, ".donePulses"}, 32'(doneCnt), 32'd1);
    checkOutput({tag, ".latency"}, 32'(doneAt), 32'(SYNC_STAGES + CONV_CYCLES + 1));
    checkOutput({tag, ".do"}, 32'(adcDo), 32'(expWord));
  endtask

  initial begin
    int doneCnt;
    modelReset();
    waitCycles(3);
    checkOutput("reset.busy", 32'(adcBusy), 32'd0);
    checkOutput("reset.done", 32'(adcDone), 32'd0);
    checkOutput("reset.do", 32'(adcDo), 32'd0);
    checkSelection("reset");
    rst_n = 1'b1;
    waitCycles(4);

    // Keyed pixel (2,2)
    applyStimulus(2, 2, 1'b1);
    checkSelection("t2");
    doConvert("t2", 1'b0);
    checkOutput("t2.literal", 32'(adcDo), 32'h1320);

    // Asynchronous reset in the middle of a conversion
    adcTrigger = 1'b1;
    waitCycles(4);
    adcTrigger = 1'b0;
    waitCycles(6);
    checkOutput("t1.busyBefore", 32'(adcBusy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t1.busy", 32'(adcBusy), 32'd0);
    checkOutput("t1.done", 32'(adcDone), 32'd0);
    checkOutput("t1.do", 32'(adcDo), 32'd0);
    checkOutput("t1.valid", 32'(selValid), 32'd0);
    waitCycles(2);
    rst_n = 1'b1;
    rowEna = 1'b0;
    modelReset();
    doneCnt = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (adcDone) doneCnt++;
    end
    checkOutput("t1.noDone", 32'(doneCnt), 32'd0);

    // Same selection with the key array cleared, then row_ena dropped
    applyStimulus(2, 2, 1'b0);
    doConvert("t3", 1'b0);
    setEna(1'b0);
    checkSelection("t3.enaLow");

    // Retrigger during CONV is dropped
    applyStimulus(5, 7, 1'b1);
    doConvert("t5", 1'b1);

    // Two ones in the column register
    clearRegs();
    shiftPair(1'b1, 1'b1, 1'b1, 1'b1);
    shiftPair(1'b1, 1'b1, 1'b0, 1'b0);
    setEna(1'b1);
    checkSelection("t4");
    doConvert("t4", 1'b0);

    // 25 ones into the column register, then key row 3 gets all ones
    clearRegs();
    for (int i = 0; i < COLS + 1; i++) shiftPair(1'b1, 1'b1, i <= 3, i == 0);
    setEna(1'b1);
    checkSelection("t6.allOnes");
    writeKey();
    applyStimulus(3, 23, 1'b0);
    doConvert("t6.pix", 1'b0);
    checkOutput("t6.literal", 32'(adcDo), 32'h15F0);

    // Column clear held across column clock edges keeps it zero
    colRst = 1'b1;
    for (int c = 0; c < COLS; c++) mCol[c] = 1'b0;
    waitCycles(HOLD);
    for (int i = 0; i < 2; i++) begin
      colData = 1'b1;
      colClk = 1'b1;
      waitCycles(HOLD);
      colClk = 1'b0;
      waitCycles(HOLD);
    end
    colRst = 1'b0;
    waitCycles(HOLD);
    checkSelection("t6.rstHeld");
    writeKey();
    applyStimulus(3, 23, 1'b0);
    doConvert("t6.cleared", 1'b0);

    // Randomized pixels, key writes and ignored writes with row_ena low
    for (int it = 0; it < 6; it++) begin
      int r = $urandom_range(0, ROWS - 1);
      int c = $urandom_range(0, COLS - 1);
      bit k = 1'($urandom_range(0, 1));
      applyStimulus(r, c, k);
      if ($urandom_range(0, 2) == 0) begin
        setEna(1'b0);
        writeKey();
        setEna(1'b1);
      end
      checkSelection($sformatf("rand%0d", it));
      doConvert($sformatf("rand%0d", it), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/speckle_chip_emulator.md
Name: speckle_chip_emulator

Overview:
- Synthesizable, cycle-accurate stand-in for the speckle sensor chip and its XADC front end, on the far side of the controller's chip and ADC interfaces.
- Receives the chip pins the controller drives: column/row shift-register clock, data, reset and enable, plus key write-enable.
- Answers conversion triggers with an XADC-style busy/eoc/do_out response that carries a deterministic per-pixel value.
- Serves closed-loop simulation and on-board loopback without the real chip.

Parameters:
COLS, 24, number of columns (width of the column shift register)
ROWS, 24, number of rows (width of the row shift register)
NB_DATA, 12, ADC result width; left-justified in a 16-bit word
SYNC_STAGES, 2, synchronizer depth on every chip-pin input (minimum 2)
CONV_CYCLES, 26, clk cycles that busy stays high per conversion (minimum 1)
PIX_BASE, 12'h100, value offset for pixels whose key bit is 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
i_chip_col_clk  in  1  column shift clock
i_chip_col_rst  in  1  column shift-register clear, level, active-high
i_chip_col_data  in  1  column serial data
i_chip_row_clk  in  1  row shift clock
i_chip_row_rst  in  1  row shift-register clear, level, active-high
i_chip_row_ena  in  1  row enable; pixel is selectable only while high
i_chip_row_data  in  1  row serial data
i_chip_key_wren  in  1  key write strobe
i_adc_trigger  in  1  convst equivalent
o_adc_busy  out  1  conversion in progress
o_adc_done  out  1  one-cycle eoc pulse
o_adc_do  out  16  result word; data in [15-:NB_DATA], low bits 0
o_sel_valid  out  1  exactly one row bit and one column bit set, and row_ena high
o_sel_err  out  1  row_ena high and either register is not one-hot
o_sel_row  out  $clog2(ROWS)  index of the selected row
o_sel_col  out  $clog2(COLS)  index of the selected column

Behaviour:
- Reset (rst_n=0, asynchronous):
  - Synchronizers, edge registers, both shift registers and the key array clear.
  - Converter returns to IDLE.
  - All outputs are 0.
- Input conditioning: every i_chip_* and i_adc_trigger passes through SYNC_STAGES flops. A rising edge is synced=1 with previous=0. All behaviour below uses the synced values.
- Column shift register (COLS bits):
  - col_rst high clears it every cycle and has priority over col_clk.
  - Otherwise, on a col_clk rising edge: sr <= {sr[COLS-2:0], col_data}, so bit 0 is the newest bit.
  - Bits shifted past COLS-1 are lost.
- Row shift register (ROWS bits): identical behaviour using row_clk, row_rst and row_data.
- Selection (registered, one cycle after the shift registers update):
  - o_sel_valid = row_ena & onehot(row_sr) & onehot(col_sr).
  - o_sel_err = row_ena & ~(onehot(row_sr) & onehot(col_sr)); an all-zero register counts as an error.
  - o_sel_row and o_sel_col hold the set-bit indices when valid, otherwise 0.
- Key array (ROWS x COLS bits):
  - On a key_wren rising edge with row_ena high, every row r with row_sr[r]=1 gets key[r] <= col_sr. Multiple rows may be written together.
  - A key_wren edge with row_ena low is ignored.
  - Only rst_n clears the array; col_rst and row_rst do not.
- Pixel value = key[row][col] ? (PIX_BASE + row*COLS + col) truncated to NB_DATA : 0. The value is 0 whenever the selection is not valid.
- Converter FSM:
  - IDLE: on a trigger rising edge, capture the pixel value, set o_adc_busy=1, load counter=CONV_CYCLES-1, go to CONV.
  - CONV: decrement the counter; when it reaches 0, go to DONE.
  - DONE: o_adc_busy=0, o_adc_done=1 for exactly one cycle, o_adc_do <= captured value << (16-NB_DATA), go to IDLE.
  - Busy is high for exactly CONV_CYCLES cycles. done follows the last busy cycle. The trigger edge-to-done latency is CONV_CYCLES+1 cycles after sync.
  - o_adc_do holds its value until the next DONE.
  - Trigger edges seen in CONV or DONE are dropped; they are not queued.
  - Changes to the selection during CONV do not affect the captured value.
- Simultaneous events:
  - A key_wren edge and a col/row clock edge in the same cycle: the key write uses the pre-shift register contents.
  - A trigger edge and a selection change in the same cycle: the capture uses the previously registered selection.

Decomposition:
- Shared package speckle_emu_pkg holds:
  - the converter state encoding (IDLE, CONV, DONE);
  - the 16-bit XADC word width;
  - a one-hot check function;
  - a one-hot-to-index function.
- One sub-module, emu_shift_reg (parameter WIDTH; inputs synced clk-edge, rst, data). It is instantiated for both columns and rows.
- The synchronizer plus edge detector stays inline as a generate loop.

Test Plan:
1. Reset mid-CONV: assert rst_n=0 during busy -> busy=0, done=0 and o_adc_do=0 immediately, with no done pulse afterwards.
2. Selection and key write:
   - Stimulus: row_rst, col_rst, then one data=1 clock followed by 2 data=0 clocks on both registers; row_ena=1; pulse key_wren.
   - Expected: o_sel_valid=1, o_sel_row=2, o_sel_col=2.
   - Then trigger -> done after 27 cycles post-sync, o_adc_do = (0x100+2*24+2)<<4 = 0x1320.
3. Same selection without a key write -> o_adc_do=0x0000. Then row_ena=0 -> o_sel_valid=0, o_sel_err=0.
4. Two 1s shifted into the column register -> o_sel_err=1, o_sel_valid=0. Trigger -> o_adc_do=0.
5. Second trigger edge 5 cycles into CONV -> exactly one done pulse, and busy is high for exactly 26 cycles.
6. Shift 25 ones into the column register (COLS=24) -> register is all ones with no overflow side effect. col_rst held high together with col_clk edges -> register stays 0.
